// File: rtl/param_shift_reg_if.sv
// Bus bundle for param_shift_reg: control/data in, register/status out.
// The register drives the status side; the controller drives the rest.
interface param_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic             sclr;
    logic             sset;
    logic             en;
    logic [2:0]       mode;
    logic             start;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output sclr, sset, en, mode, start,
        output sin_l, sin_r, d,
        input  q, ser_out, busy, done
    );

    modport slave (
        input  sclr, sset, en, mode, start,
        input  sin_l, sin_r, d,
        output q, ser_out, busy, done
    );
endinterface

// File: rtl/param_shift_reg.sv
// WIDTH-bit mode register with sync clear/set and an LSB-first serializer.
// Async active-high reset; serializer runs WIDTH shifts after a start load.
module param_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input logic               clk,
    input logic               reset,
    param_shift_reg_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_INV  = 3'b110;

    logic [WIDTH-1:0] q_q, q_d;
    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state: clear/set win, then an active frame, then start, then mode ops.
    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (bus.sclr || bus.sset) begin
            q_d     = bus.sclr ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            q_d   = {bus.sin_l, q_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else if (bus.start) begin
            q_d     = bus.d;
            cnt_d   = '0;
            state_d = SHIFT;
            busy_d  = 1'b1;
        end else if (bus.en) begin
            unique case (bus.mode)
                M_SHL:   q_d = {q_q[WIDTH-2:0], bus.sin_r};
                M_SHR:   q_d = {bus.sin_l, q_q[WIDTH-1:1]};
                M_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                M_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                M_LOAD:  q_d = bus.d;
                M_INV:   q_d = ~q_q;
                M_HOLD:  q_d = q_q;
                default: q_d = q_q;
            endcase
        end
    end

    // State flops; reset aborts any frame without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= RESET_VAL;
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.ser_out = q_q[0];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_param_shift_reg.sv
// Bench for param_shift_reg (WIDTH=8): reference model checked every cycle
// plus directed vectors with hand-computed literal expectations.
module tb_param_shift_reg;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    param_shift_reg_if #(.WIDTH(W)) bus ();

    param_shift_reg #(
        .WIDTH(W),
        .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: register value, frame bookkeeping as bits still to send.
    logic [W-1:0] mq;
    logic         frame;
    int           left;
    logic         mdone;
    logic         mvalid = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq     <= '0;
            frame  <= 1'b0;
            left   <= 0;
            mdone  <= 1'b0;
            mvalid <= 1'b1;
        end else begin
            mdone <= 1'b0;
            if (bus.sclr) begin
                mq    <= '0;
                frame <= 1'b0;
                left  <= 0;
            end else if (bus.sset) begin
                mq    <= '1;
                frame <= 1'b0;
                left  <= 0;
            end else if (frame) begin
                mq   <= (mq >> 1) | (8'(bus.sin_l) << 7);
                left <= left - 1;
                if (left == 1) begin
                    frame <= 1'b0;
                    mdone <= 1'b1;
                end
            end else if (bus.start) begin
                mq    <= bus.d;
                frame <= 1'b1;
                left  <= W;
            end else if (bus.en) begin
                case (bus.mode)
                    3'd1: mq <= (mq << 1) | 8'(bus.sin_r);
                    3'd2: mq <= (mq >> 1) | (8'(bus.sin_l) << 7);
                    3'd3: mq <= (mq << 1) | (mq >> 7);
                    3'd4: mq <= (mq >> 1) | (mq << 7);
                    3'd5: mq <= bus.d;
                    3'd6: mq <= ~mq;
                    default: mq <= mq;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset && mvalid) begin
            check("model_q", 32'(bus.q), 32'(mq));
            check("model_busy", 32'(bus.busy), 32'(frame));
            check("model_done", 32'(bus.done), 32'(mdone));
            check("model_ser", 32'(bus.ser_out), 32'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ser_bits[8] = '{1, 1, 0, 0, 0, 0, 1, 1};
    int done_seen;

    initial begin
        bus.sclr  = 1'b0;
        bus.sset  = 1'b0;
        bus.en    = 1'b0;
        bus.mode  = 3'd0;
        bus.start = 1'b0;
        bus.sin_l = 1'b0;
        bus.sin_r = 1'b0;
        bus.d     = 8'h00;
        #1 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_q", 32'(bus.q), 32'h00);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);

        // Load, rotate, invert, hold with en=0
        bus.en = 1'b1; bus.mode = 3'b101; bus.d = 8'hA5;
        tick(); check("load_a5", 32'(bus.q), 32'hA5);
        bus.mode = 3'b011;
        tick(); check("rol", 32'(bus.q), 32'h4B);
        bus.mode = 3'b100;
        tick(); check("ror", 32'(bus.q), 32'hA5);
        bus.mode = 3'b110;
        tick(); check("inv", 32'(bus.q), 32'h5A);
        bus.en = 1'b0; bus.mode = 3'b101; bus.d = 8'h00;
        tick(); check("en0_load", 32'(bus.q), 32'h5A);
        bus.mode = 3'b110;
        tick(); check("en0_inv", 32'(bus.q), 32'h5A);

        // Shifts and hold modes
        bus.en = 1'b1; bus.mode = 3'b101; bus.d = 8'h80;
        tick(); check("load_80", 32'(bus.q), 32'h80);
        bus.mode = 3'b001; bus.sin_r = 1'b1;
        tick(); check("shl", 32'(bus.q), 32'h01);
        bus.mode = 3'b010; bus.sin_l = 1'b1;
        tick(); check("shr", 32'(bus.q), 32'h80);
        bus.mode = 3'b000;
        tick(); check("hold000", 32'(bus.q), 32'h80);
        bus.mode = 3'b111;
        tick(); check("hold111", 32'(bus.q), 32'h80);
        bus.sin_l = 1'b0; bus.sin_r = 1'b0;

        // Sync set / clear act only at the edge, regardless of en
        bus.en = 1'b0; bus.sset = 1'b1;
        #2 check("sset_pre", 32'(bus.q), 32'h80);
        tick(); check("sset", 32'(bus.q), 32'hFF);
        bus.sclr = 1'b1;
        #2 check("both_pre", 32'(bus.q), 32'hFF);
        tick(); check("both", 32'(bus.q), 32'h00);
        bus.sclr = 1'b0; bus.sset = 1'b0;

        // Async reset between edges, edges ignored while held
        bus.en = 1'b1; bus.mode = 3'b101; bus.d = 8'h5A;
        tick(); check("load_5a", 32'(bus.q), 32'h5A);
        #3 reset = 1'b1;
        #1 check("areset_q", 32'(bus.q), 32'h00);
        check("areset_busy", 32'(bus.busy), 32'h0);
        tick(); tick();
        check("areset_hold", 32'(bus.q), 32'h00);
        reset = 1'b0;
        bus.en = 1'b0; bus.mode = 3'b000;

        // Serializer frame 0xC3, stray start mid-frame, back-to-back start
        bus.d = 8'hC3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ser_load", 32'(bus.q), 32'hC3);
        for (int i = 0; i < 8; i++) begin
            check("ser_bit", 32'(bus.ser_out), 32'(ser_bits[i]));
            check("ser_busy", 32'(bus.busy), 32'h1);
            check("ser_nodone", 32'(bus.done), 32'h0);
            if (i == 3) begin
                bus.start = 1'b1; bus.d = 8'hFF; bus.en = 1'b1; bus.mode = 3'b110;
            end else begin
                bus.start = 1'b0; bus.en = 1'b0; bus.mode = 3'b000;
            end
            tick();
        end
        check("ser_done", 32'(bus.done), 32'h1);
        check("ser_idle", 32'(bus.busy), 32'h0);
        check("ser_final", 32'(bus.q), 32'h00);
        bus.d = 8'h96; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("b2b_q", 32'(bus.q), 32'h96);
        check("b2b_busy", 32'(bus.busy), 32'h1);
        check("b2b_done", 32'(bus.done), 32'h0);
        repeat (8) tick();
        check("b2b_done2", 32'(bus.done), 32'h1);
        check("b2b_final", 32'(bus.q), 32'h00);
        tick();
        check("b2b_pulse", 32'(bus.done), 32'h0);

        // Abort by sclr at the 3rd shift
        bus.d = 8'hFF; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        bus.sclr = 1'b1;
        tick();
        bus.sclr = 1'b0;
        check("abort_q", 32'(bus.q), 32'h00);
        check("abort_busy", 32'(bus.busy), 32'h0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) done_seen++;
            tick();
        end
        check("abort_nodone", 32'(done_seen), 32'h0);

        // Abort by async reset mid-frame
        bus.d = 8'hFF; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        #3 reset = 1'b1;
        #1 check("rabort_q", 32'(bus.q), 32'h00);
        check("rabort_busy", 32'(bus.busy), 32'h0);
        check("rabort_done", 32'(bus.done), 32'h0);
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) done_seen++;
            tick();
        end
        check("rabort_nodone", 32'(done_seen), 32'h0);
        check("rabort_idle", 32'(bus.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
